// File: rtl/hs32_intc_pkg.sv
// Shared constants for the hs32 interrupt controller: FSM encodings, vector
// stride default, mask reset value and the vector address helper.
package hs32_intc_pkg;

    localparam int unsigned IDX_W          = 5;
    localparam int unsigned VEC_STRIDE_DEF = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_SVC  = 2'd2;

    // Every channel starts masked; sliced to NCH bits by the user.
    localparam logic [31:0] MASK_RST = 32'hFFFF_FFFF;

    // Slot 0 of the vector table is reserved, so channel n lives at slot n+1.
    function automatic logic [31:0] vec_addr(input logic [31:0]      base,
                                             input logic [IDX_W-1:0] idx,
                                             input logic [31:0]      stride);
        logic [31:0] slot;
        slot = {{(32-IDX_W){1'b0}}, idx} + 32'd1;
        return base + stride * slot;
    endfunction

endpackage

// File: rtl/hs32_intc_if.sv
// CPU-side bundle of the interrupt controller: requests, mask port, vector
// handshake (intrq/ack/eoi) and status.
interface hs32_intc_if #(
    parameter int NCH = 24
) ();
    logic            enable;
    logic [NCH-1:0]  irq;
    logic [31:0]     base;
    logic            mask_we;
    logic [NCH-1:0]  mask_wdata;
    logic            ack;
    logic            eoi;
    logic            intrq;
    logic [31:0]     addi;
    logic [NCH-1:0]  pending;
    logic            busy;

    modport master (
        output enable, irq, base, mask_we, mask_wdata, ack, eoi,
        input  intrq, addi, pending, busy
    );

    modport slave (
        input  enable, irq, base, mask_we, mask_wdata, ack, eoi,
        output intrq, addi, pending, busy
    );
endinterface

// File: rtl/hs32_prio_enc.sv
// Lowest-index-first priority encoder; purely combinational.
module hs32_prio_enc
    import hs32_intc_pkg::*;
#(
    parameter int NCH = 24
) (
    input  logic [NCH-1:0]   req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);

    // Scan downwards so the last hit, i.e. the lowest set index, wins.
    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = i[IDX_W-1:0];
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hs32_intc.sv
// Vectored interrupt controller: sticky pending, mask, IDLE->REQ->SVC handshake.
// Level capture by default; rising-edge capture with HS32_INTC_EDGE_EN defined.
module hs32_intc
    import hs32_intc_pkg::*;
#(
    parameter int NCH        = 24,
    parameter int VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    hs32_intc_if.slave bus
);

    logic [1:0]       state_q, state_d;
    logic [NCH-1:0]   pending_q, pending_d;
    logic [NCH-1:0]   mask_q, mask_d;
    logic [IDX_W-1:0] cur_q, cur_d;
    logic             intrq_q, intrq_d;
    logic [31:0]      addi_q, addi_d;
    logic             busy_q, busy_d;

    logic [NCH-1:0]   cap;
    logic [NCH-1:0]   clr_vec;
    logic [NCH-1:0]   eligible;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_vld;

`ifdef HS32_INTC_EDGE_EN
    logic [NCH-1:0] irq_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_prev_q <= '0;
        end else begin
            irq_prev_q <= bus.irq;
        end
    end

    assign cap = bus.irq & ~irq_prev_q;
`else
    assign cap = bus.irq;
`endif

    assign eligible = pending_q & ~mask_q;

    hs32_prio_enc #(
        .NCH (NCH)
    ) u_prio (
        .req_i (eligible),
        .idx_o (sel_idx),
        .vld_o (sel_vld)
    );

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        intrq_d = intrq_q;
        addi_d  = addi_q;
        busy_d  = busy_q;
        clr_vec = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.enable && sel_vld) begin
                    cur_d   = sel_idx;
                    intrq_d = 1'b1;
                    addi_d  = vec_addr(bus.base, sel_idx, 32'(VEC_STRIDE));
                    state_d = ST_REQ;
                end
            end
            // cur is frozen here: neither priority nor mask changes re-arbitrate.
            ST_REQ: begin
                if (bus.ack) begin
                    clr_vec = NCH'(1) << cur_q;
                    intrq_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_SVC;
                end
            end
            ST_SVC: begin
                if (bus.eoi) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                intrq_d = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // A capture in the same cycle as the ack clear keeps the bit set.
    assign pending_d = (pending_q & ~clr_vec) | cap;
    assign mask_d    = bus.mask_we ? bus.mask_wdata : mask_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            mask_q    <= MASK_RST[NCH-1:0];
            cur_q     <= '0;
            intrq_q   <= 1'b0;
            addi_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            cur_q     <= cur_d;
            intrq_q   <= intrq_d;
            addi_q    <= addi_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.intrq   = intrq_q;
    assign bus.addi    = addi_q;
    assign bus.pending = pending_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_hs32_intc.sv
// Directed bench for hs32_intc; expectations are hand-computed per step.
module tb_hs32_intc;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   grants;

    hs32_intc_if #(.NCH(24)) bus ();

    hs32_intc #(
        .NCH        (24),
        .VEC_STRIDE (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic serve();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
    endtask

    task automatic pulse(input logic [23:0] lines);
        bus.irq = lines;
        tick();
        bus.irq = '0;
    endtask

    task automatic write_mask(input logic [23:0] m);
        bus.mask_we    = 1'b1;
        bus.mask_wdata = m;
        tick();
        bus.mask_we    = 1'b0;
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        grants         = 0;
        reset          = 1'b1;
        bus.enable     = 1'b0;
        bus.irq        = '0;
        bus.base       = 32'h0000_1000;
        bus.mask_we    = 1'b0;
        bus.mask_wdata = '0;
        bus.ack        = 1'b0;
        bus.eoi        = 1'b0;
        tick();
        tick();
        reset      = 1'b0;
        bus.enable = 1'b1;
        tick();
        chk("rst_intrq",   32'(bus.intrq),   32'h0);
        chk("rst_addi",    bus.addi,         32'h0);
        chk("rst_busy",    32'(bus.busy),    32'h0);
        chk("rst_pending", 32'(bus.pending), 32'h0);

        // Reset mask is all ones: a request pends but never issues.
        pulse(24'h000008);
        tick();
        tick();
        chk("rstmask_pending", 32'(bus.pending), 32'h8);
        chk("rstmask_intrq",   32'(bus.intrq),   32'h0);
        write_mask(24'h0);
        tick();
        chk("ch3_intrq", 32'(bus.intrq), 32'h1);
        chk("ch3_addi",  bus.addi,       32'h0000_1010);
        serve();

        // Single pulse on channel 0: intrq two edges after the capturing edge's request.
        bus.irq = 24'h000001;
        tick();
        bus.irq = '0;
        chk("ch0_intrq_early", 32'(bus.intrq), 32'h0);
        tick();
        chk("ch0_intrq", 32'(bus.intrq), 32'h1);
        chk("ch0_addi",  bus.addi,       32'h0000_1004);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("ch0_ack_pending", 32'(bus.pending), 32'h0);
        chk("ch0_ack_busy",    32'(bus.busy),    32'h1);
        chk("ch0_ack_intrq",   32'(bus.intrq),   32'h0);
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        chk("ch0_eoi_busy", 32'(bus.busy), 32'h0);

        // Channels 5 and 2 together: 2 first, then 5; ch0 arriving in REQ does not preempt.
        pulse(24'h000024);
        chk("pri_pending", 32'(bus.pending), 32'h24);
        tick();
        chk("pri_ch2_addi", bus.addi, 32'h0000_100C);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("pri_ack_pending", 32'(bus.pending), 32'h20);
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        chk("pri_eoi_intrq", 32'(bus.intrq), 32'h0);
        tick();
        chk("pri_ch5_intrq", 32'(bus.intrq), 32'h1);
        chk("pri_ch5_addi",  bus.addi,       32'h0000_1018);
        pulse(24'h000001);
        tick();
        chk("hold_addi",    bus.addi,         32'h0000_1018);
        chk("hold_intrq",   32'(bus.intrq),   32'h1);
        chk("hold_pending", 32'(bus.pending), 32'h21);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("hold_ack_pending", 32'(bus.pending), 32'h1);
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        tick();
        chk("late_ch0_addi", bus.addi, 32'h0000_1004);
        serve();

        // Masked channel still pends; unmasking releases it.
        write_mask(24'h000004);
        pulse(24'h000004);
        tick();
        tick();
        chk("mask_pending", 32'(bus.pending), 32'h4);
        chk("mask_intrq",   32'(bus.intrq),   32'h0);
        write_mask(24'h0);
        tick();
        chk("unmask_intrq", 32'(bus.intrq), 32'h1);
        chk("unmask_addi",  bus.addi,       32'h0000_100C);
        serve();

        // Requests during SVC wait for eoi, then issue one cycle after IDLE.
        pulse(24'h000002);
        tick();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        pulse(24'h000001);
        tick();
        tick();
        chk("svc_intrq",   32'(bus.intrq),   32'h0);
        chk("svc_pending", 32'(bus.pending), 32'h1);
        chk("svc_busy",    32'(bus.busy),    32'h1);
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        chk("svc_eoi_intrq", 32'(bus.intrq), 32'h0);
        tick();
        chk("svc_next_intrq", 32'(bus.intrq), 32'h1);
        chk("svc_next_addi",  bus.addi,       32'h0000_1004);
        serve();

        // Stray ack in IDLE and stray eoi in REQ are ignored.
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("stray_ack_busy", 32'(bus.busy), 32'h0);
        pulse(24'h000001);
        tick();
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        chk("stray_eoi_intrq", 32'(bus.intrq), 32'h1);
        chk("stray_eoi_busy",  32'(bus.busy),  32'h0);

        // Capture coinciding with ack on cur: set wins.
        bus.irq = 24'h000001;
        bus.ack = 1'b1;
        tick();
        bus.irq = '0;
        bus.ack = 1'b0;
        chk("setwins_pending", 32'(bus.pending), 32'h1);
        chk("setwins_busy",    32'(bus.busy),    32'h1);
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        tick();
        chk("setwins_reissue", 32'(bus.intrq), 32'h1);
        serve();

        // enable=0 blocks issue only; an issued request still completes.
        bus.enable = 1'b0;
        pulse(24'h000001);
        tick();
        tick();
        chk("en0_intrq",   32'(bus.intrq),   32'h0);
        chk("en0_pending", 32'(bus.pending), 32'h1);
        bus.enable = 1'b1;
        tick();
        chk("en1_intrq", 32'(bus.intrq), 32'h1);
        bus.enable = 1'b0;
        bus.ack    = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("en0_ack_busy", 32'(bus.busy), 32'h1);
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        chk("en0_eoi_busy", 32'(bus.busy), 32'h0);
        bus.enable = 1'b1;

        // Vector address wraps modulo 2^32.
        bus.base = 32'hFFFF_FFFC;
        pulse(24'h000001);
        tick();
        chk("wrap_intrq", 32'(bus.intrq), 32'h1);
        chk("wrap_addi",  bus.addi,       32'h0000_0000);
        serve();

        // Reset in REQ aborts at once and restores the all-ones mask.
        bus.base = 32'h0000_1000;
        pulse(24'h00000A);
        tick();
        chk("prereset_intrq", 32'(bus.intrq), 32'h1);
        reset = 1'b1;
        #1;
        chk("midrst_intrq",   32'(bus.intrq),   32'h0);
        chk("midrst_pending", 32'(bus.pending), 32'h0);
        chk("midrst_busy",    32'(bus.busy),    32'h0);
        chk("midrst_addi",    bus.addi,         32'h0);
        tick();
        reset    = 1'b0;
        bus.base = 32'h0000_2000;
        pulse(24'h000001);
        tick();
        tick();
        chk("postrst_mask_intrq",   32'(bus.intrq),   32'h0);
        chk("postrst_mask_pending", 32'(bus.pending), 32'h1);
        write_mask(24'h0);
        tick();
        chk("postrst_addi", bus.addi, 32'h0000_2004);
        serve();

        // irq[1] held for 10 cycles with a prompt CPU: one grant on edge capture, three on level.
        bus.irq = 24'h000002;
        for (int i = 0; i < 10; i++) begin
            bus.ack = bus.intrq;
            bus.eoi = bus.busy;
            if (bus.intrq) grants++;
            tick();
        end
        bus.irq = '0;
        bus.ack = 1'b0;
        bus.eoi = 1'b0;
`ifdef HS32_INTC_EDGE_EN
        chk("held_grants",  32'(grants),      32'd1);
        chk("held_pending", 32'(bus.pending), 32'h0);
`else
        chk("held_grants",  32'(grants),      32'd3);
        chk("held_pending", 32'(bus.pending), 32'h2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hs32_intc.md
HS32_INTC -- requirements
Module: hs32_intc

Interface
REQ-001 SHALL have parameter NCH, default 24, number of interrupt channels (1..32).
REQ-002 SHALL have parameter VEC_STRIDE, default 4, byte spacing between vector slots.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  global interrupt enable.
REQ-006 SHALL have port irq  input  NCH  per-channel request lines; channel 0 is highest priority.
REQ-007 SHALL have port base  input  32  vector table base address.
REQ-008 SHALL have port mask_we  input  1  mask register write strobe.
REQ-009 SHALL have port mask_wdata  input  NCH  new mask; bit set = channel masked.
REQ-010 SHALL have port ack  input  1  CPU accepts the presented request.
REQ-011 SHALL have port eoi  input  1  CPU signals end of handler.
REQ-012 SHALL have port intrq  output  1  interrupt request to CPU.
REQ-013 SHALL have port addi  output  32  handler vector address, valid while intrq=1.
REQ-014 SHALL have port pending  output  NCH  pending register, readable.
REQ-015 SHALL have port busy  output  1  handler in service.

Function
REQ-016 SHALL set pending[i] on the rising edge at which a request on irq[i] is captured; pending bits are sticky until cleared by ack.
REQ-017 SHALL implement FSM IDLE -> REQ -> SVC -> IDLE.
REQ-018 IDLE: if enable=1 and (pending & ~mask)!=0, SHALL latch the lowest-index eligible channel as cur, register intrq=1 and addi=base+VEC_STRIDE*(cur+1), enter REQ; latency one cycle after pending sets.
REQ-019 REQ: intrq and addi SHALL hold stable until ack=1; on ack, SHALL clear pending[cur], drop intrq, set busy=1, enter SVC.
REQ-020 REQ: the selected channel SHALL NOT change while waiting for ack, even if a higher-priority channel becomes pending or cur is masked.
REQ-021 SVC: SHALL ignore new requests (they accumulate in pending); on eoi SHALL clear busy and enter IDLE; next request may issue one cycle later.
REQ-022 ack outside REQ and eoi outside SVC SHALL be ignored.
REQ-023 If capture on channel cur coincides with ack clearing it, pending[cur] SHALL remain set (set wins).
REQ-024 mask_we SHALL load the mask in one cycle; a masked channel SHALL still latch pending.
REQ-025 enable=0 SHALL only block IDLE->REQ; REQ and SVC SHALL complete normally.
REQ-026 addi arithmetic SHALL be 32-bit modulo; overflow wraps silently.

Reset
REQ-027 On reset SHALL force: state=IDLE, pending=0, mask=all ones, intrq=0, addi=0, busy=0, cur=0, edge history=0.
REQ-028 Reset asserted mid-REQ or mid-SVC SHALL abort immediately; pending requests are lost.

Configuration
REQ-029 With HS32_INTC_EDGE_EN defined, capture SHALL be rising-edge: pending[i] sets when irq[i]=1 and the registered previous sample=0; a held-high line pends once.
REQ-030 Without HS32_INTC_EDGE_EN, capture SHALL be level: pending[i] sets every cycle irq[i]=1, so a held line re-pends immediately after ack; no history register exists.

Structure
REQ-031 FSM state encodings, VEC_STRIDE default and reset mask value SHALL live in shared package hs32_intc_pkg.
REQ-032 Lowest-index-first selection SHALL be a sub-module hs32_prio_enc (NCH-wide in, index + valid out, combinational).

Verification
REQ-033 base=0x1000, mask=0, enable=1, pulse irq[0] -> intrq=1 two edges later, addi=0x1004; ack -> pending[0]=0, busy=1.
REQ-034 irq[5] and irq[2] high in the same cycle -> addi=base+0x0C (ch2); after ack+eoi -> addi=base+0x18 (ch5).
REQ-035 mask=0x4, irq[2] pulsed -> pending[2]=1, intrq=0; write mask=0 -> intrq=1, addi=base+0x0C.
REQ-036 In SVC assert irq[0] -> no intrq until eoi; intrq=1 one cycle after IDLE is re-entered.
REQ-037 base=0xFFFFFFFC, irq[0] -> addi=0x00000000 (wrap).
REQ-038 Assert reset during REQ -> intrq=0, pending=0, mask=all ones that cycle; EDGE_EN on/off: irq[1] held 10 cycles -> one vs repeated requests.
